// File: rtl/tsc_pkg.sv
// Shared types and constants for the trigger-surround capture cache.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tsc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FILL      = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POST      = 3'd3,
    ST_DONE      = 3'd4,
    ST_SEND      = 3'd5
  } state_t;

  localparam int MODE_RISE   = 0;
  localparam int MODE_FALL   = 1;
  localparam int MODE_EITHER = 2;

  localparam int TS_W = 32;

  // Select which threshold crossing counts as a trigger for a given edge mode.
  function automatic logic edge_hit(input int mode, input logic rise, input logic fall);
    case (mode)
      MODE_RISE: return rise;
      MODE_FALL: return fall;
      default:   return rise | fall;
    endcase
  endfunction

endpackage

// File: rtl/tsc_ring_buf.sv
// Sample ring storage: DW x DEPTH, one synchronous write port, one async read port.
// Latency: write visible the cycle after i_we; read is combinational.
// Backpressure: none; caller owns pointer wrap and write gating.
module tsc_ring_buf #(
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  // Store one sample per enabled cycle; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/trig_surround_cache_p.sv
// Captures PRE samples before and POST after a threshold crossing, then streams them oldest first.
// Latency: trigger flags one cycle after the trigger sample; dat valid in the same cycle as rdy.
// Backpressure: host req gates each word; the ring is frozen from capture done until send done.
module trig_surround_cache_p
  import tsc_pkg::*;
#(
  parameter int DW   = 8,
  parameter int PRE  = 4,
  parameter int POST = 3,
  parameter int MODE = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [DW-1:0]   adc_data,
  input  logic            adc_valid,
  input  logic [DW-1:0]   thr,
  input  logic            sbf,
  input  logic            req,
  output logic            trd,
  output logic            cd,
  output logic [TS_W-1:0] trigtm,
  output logic            rdy,
  output logic [DW-1:0]   dat,
  output logic            sd
);

  localparam int DEPTH = PRE + POST + 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);

  localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);
  localparam logic [CW-1:0] PRE_M1    = CW'((PRE > 0) ? PRE - 1 : 0);
  localparam logic [CW-1:0] POST_M1   = CW'((POST > 0) ? POST - 1 : 0);
  localparam logic [CW-1:0] LAST_WORD = CW'(DEPTH - 1);

  state_t          r_state;
  logic [DW-1:0]   r_thr;
  logic [DW-1:0]   r_prev;
  logic            r_prev_vld;
  logic [TS_W-1:0] r_ts;
  logic [TS_W-1:0] r_trigtm;
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW-1:0]   r_trig_idx;
  logic [CW-1:0]   r_cnt;
  logic            r_trd;
  logic            r_cd;
  logic            r_rdy;
  logic            r_sd;

  logic            w_wr;
  logic            w_rise;
  logic            w_fall;
  logic            w_hit;
  logic [AW-1:0]   w_wptr_nxt;
  logic [AW-1:0]   w_rptr_nxt;
  logic [AW-1:0]   w_rd_start;
  logic [DW-1:0]   w_rdata;

  // Samples are only stored while capturing; DONE/SEND keep the ring frozen.
  assign w_wr = adc_valid &&
                ((r_state == ST_FILL) || (r_state == ST_WAIT_TRIG) || (r_state == ST_POST));

  assign w_rise = (r_prev < r_thr) && (adc_data >= r_thr);
  assign w_fall = (r_prev > r_thr) && (adc_data <= r_thr);
  assign w_hit  = r_prev_vld && edge_hit(MODE, w_rise, w_fall);

  assign w_wptr_nxt = (r_wptr == LAST_IDX) ? '0 : r_wptr + 1'b1;
  assign w_rptr_nxt = (r_rptr == LAST_IDX) ? '0 : r_rptr + 1'b1;

  // Oldest kept sample sits PRE slots behind the trigger slot, modulo ring depth.
  always_comb begin
    w_rd_start = r_trig_idx;
    if (int'(r_trig_idx) >= PRE) w_rd_start = AW'(int'(r_trig_idx) - PRE);
    else                         w_rd_start = AW'(int'(r_trig_idx) + DEPTH - PRE);
  end

  tsc_ring_buf #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_ring (
    .clk     (clk),
    .i_we    (w_wr),
    .i_waddr (r_wptr),
    .i_wdata (adc_data),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

  // Capture/send sequencer with registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_thr      <= '0;
      r_prev     <= '0;
      r_prev_vld <= 1'b0;
      r_ts       <= '0;
      r_trigtm   <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_trig_idx <= '0;
      r_cnt      <= '0;
      r_trd      <= 1'b0;
      r_cd       <= 1'b0;
      r_rdy      <= 1'b0;
      r_sd       <= 1'b0;
    end else begin
      r_sd <= 1'b0;
      if (r_state != ST_IDLE) r_ts <= r_ts + 1'b1;
      if (w_wr) begin
        r_wptr     <= w_wptr_nxt;
        r_prev     <= adc_data;
        r_prev_vld <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_thr      <= thr;
            r_ts       <= '0;
            r_cnt      <= '0;
            r_wptr     <= '0;
            r_prev_vld <= 1'b0;
            r_state    <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (PRE == 0) begin
            r_state <= ST_WAIT_TRIG;
          end else if (w_wr) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == PRE_M1) r_state <= ST_WAIT_TRIG;
          end
        end
        ST_WAIT_TRIG: begin
          if (w_wr && w_hit) begin
            r_trigtm   <= r_ts;
            r_trd      <= 1'b1;
            r_trig_idx <= r_wptr;
            r_cnt      <= '0;
            if (POST == 0) begin
              r_cd    <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_POST;
            end
          end
        end
        ST_POST: begin
          if (w_wr) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == POST_M1) begin
              r_cd    <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (sbf) begin
            r_cd    <= 1'b0;
            r_rptr  <= w_rd_start;
            r_cnt   <= '0;
            r_rdy   <= 1'b1;
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (req) begin
            r_rptr <= w_rptr_nxt;
            r_cnt  <= r_cnt + 1'b1;
            if (r_cnt == LAST_WORD) begin
              r_rdy   <= 1'b0;
              r_sd    <= 1'b1;
              r_trd   <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign trd    = r_trd;
  assign cd     = r_cd;
  assign trigtm = r_trigtm;
  assign rdy    = r_rdy;
  assign sd     = r_sd;
  // Word is driven only while offered, so the bus idles at zero.
  assign dat    = r_rdy ? w_rdata : '0;

endmodule

// File: tb/tb_trig_surround_cache_p.sv
module tb_trig_surround_cache_p;

  localparam int PRE   = 4;
  localparam int POST  = 3;
  localparam int L     = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, adc_valid, sbf, req;
  logic [7:0]  adc_data, thr;
  logic        trd, cd, rdy, sd;
  logic [31:0] trigtm;
  logic [7:0]  dat;

  logic        start1, adc_valid1, sbf1, req1;
  logic [7:0]  adc_data1, thr1;
  logic        trd1, cd1, rdy1, sd1;
  logic [31:0] trigtm1;
  logic [7:0]  dat1;

  always #5 clk = ~clk;

  trig_surround_cache_p #(.DW(8), .PRE(PRE), .POST(POST), .MODE(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .adc_data(adc_data), .adc_valid(adc_valid),
    .thr(thr), .sbf(sbf), .req(req), .trd(trd), .cd(cd), .trigtm(trigtm),
    .rdy(rdy), .dat(dat), .sd(sd));

  trig_surround_cache_p #(.DW(8), .PRE(PRE), .POST(POST), .MODE(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .adc_data(adc_data1), .adc_valid(adc_valid1),
    .thr(thr1), .sbf(sbf1), .req(req1), .trd(trd1), .cd(cd1), .trigtm(trigtm1),
    .rdy(rdy1), .dat(dat1), .sd(sd1));

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic       exp_sd  = 1'b0;
  logic       sd_seen = 1'b0;

  logic [7:0] g_samp[L];
  logic       g_vld[L];

  // Reference model results
  int         m_trig_c;
  int         m_done_c;
  logic [7:0] m_words[$];

  logic [7:0] seq_a[10] = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd90, 8'd120, 8'd130, 8'd140, 8'd150};
  logic [7:0] seq_b[11] = '{8'd50, 8'd150, 8'd160, 8'd170, 8'd180, 8'd90, 8'd95, 8'd130, 8'd140, 8'd150, 8'd160};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: list valid samples in arrival order; the first PRE are history only,
  // the first later sample crossing the threshold (vs its predecessor) is the trigger,
  // and the captured window is PRE before it through POST after it.
  task automatic model(input int mode, input logic [7:0] t);
    logic [7:0] v[$];
    int         cy[$];
    int         k;
    logic       up, dn;
    v = {}; cy = {}; m_words = {};
    m_trig_c = -1; m_done_c = -1; k = -1;
    for (int c = 0; c < L; c++) begin
      if (g_vld[c]) begin
        v.push_back(g_samp[c]);
        cy.push_back(c);
      end
    end
    for (int i = PRE; i < v.size(); i++) begin
      if (k < 0) begin
        up = (v[i-1] < t) && (v[i] >= t);
        dn = (v[i-1] > t) && (v[i] <= t);
        if ((mode == 0 && up) || (mode == 1 && dn) || (mode == 2 && (up || dn))) k = i;
      end
    end
    if (k >= 0) begin
      m_trig_c = cy[k];
      if (k + POST < v.size()) begin
        m_done_c = cy[k + POST];
        for (int i = k - PRE; i <= k + POST; i++) m_words.push_back(v[i]);
      end
    end
  endtask

  task automatic load_a();
    for (int c = 0; c < L; c++) begin
      if (c < 10) begin
        g_samp[c] = seq_a[c];
        g_vld[c]  = 1'b1;
      end else begin
        g_samp[c] = 8'($urandom);
        g_vld[c]  = 1'($urandom);
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_trd"},    32'(trd),    32'd0);
    chk({tag, "_cd"},     32'(cd),     32'd0);
    chk({tag, "_rdy"},    32'(rdy),    32'd0);
    chk({tag, "_sd"},     32'(sd),     32'd0);
    chk({tag, "_trigtm"}, trigtm,      32'd0);
    chk({tag, "_dat"},    32'(dat),    32'd0);
  endtask

  // One capture + send episode on dut0 (MODE 0).
  // force_at >= 0 presets the timestamp during that cycle; abort_at >= 0 resets mid-capture.
  // req_mode: 0 always, 1 toggle every other cycle, 2 random.
  task automatic run_capture(input logic [7:0] t, input int force_at, input int abort_at, input int req_mode);
    logic [31:0] exp_tm;
    model(0, t);
    if (m_done_c < 0) begin
      total++; bad++;
      $display("FAIL gen: no complete capture in stimulus (thr=%0d)", t);
      return;
    end
    @(posedge clk); #1;
    start = 1'b1; thr = t; sbf = 1'b0; req = 1'b0;
    for (int c = 0; c < L; c++) begin
      @(posedge clk); #1;
      if (c > 0) begin
        chk("trd", 32'(trd), 32'(m_trig_c <= c - 1));
        chk("cd",  32'(cd),  32'(m_done_c <= c - 1));
      end
      if (c == abort_at) begin
        start = 1'b0; adc_valid = 1'b0; sbf = 1'b0;
        #2 reset = 1'b1;
        #1 chk_reset_outputs("rst_mid");
        #1 reset = 1'b0;
        return;
      end
      start     = 1'($urandom);
      sbf       = (c <= m_done_c) ? 1'($urandom) : 1'b0;
      adc_data  = g_samp[c];
      adc_valid = g_vld[c];
      if (c == force_at) begin
        force dut0.r_ts = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut0.r_ts;
      end
    end
    @(posedge clk); #1;
    start = 1'b0; adc_valid = 1'b0;
    exp_tm = (force_at >= 0 && m_trig_c >= force_at) ?
             32'hFFFF_FFFE + 32'(m_trig_c - force_at) : 32'(m_trig_c);
    chk("trd_done", 32'(trd), 32'd1);
    chk("cd_done",  32'(cd),  32'd1);
    chk("rdy_idle", 32'(rdy), 32'd0);
    chk("trigtm",   trigtm,   exp_tm);

    foreach (m_words[i]) exp_q.push_back(m_words[i]);
    sd_seen = 1'b0;
    sbf = 1'b1;
    @(posedge clk); #1;
    sbf = 1'b0;
    chk("cd_clr",   32'(cd),  32'd0);
    chk("rdy_send", 32'(rdy), 32'd1);
    for (int n = 0; n < 300 && !sd_seen; n++) begin
      req = (req_mode == 0) ? 1'b1 : (req_mode == 1) ? n[0] : 1'($urandom);
      @(posedge clk); #1;
    end
    req = 1'b0;
    if (!sd_seen) begin
      total++; bad++;
      $display("FAIL send_timeout: sd not seen, %0d words left", exp_q.size());
    end
    chk("words_left", 32'(exp_q.size()), 32'd0);
    exp_q = {};
    chk("trd_clr", 32'(trd), 32'd0);
  endtask

  // Monitor: pops expected words on every transfer and checks the sd pulse.
  always @(negedge clk) begin
    if (sd || exp_sd) begin
      chk("sd_pulse", 32'(sd), 32'(exp_sd));
      if (exp_sd) chk("rdy_after_last", 32'(rdy), 32'd0);
      if (sd) sd_seen = 1'b1;
    end
    exp_sd = 1'b0;
    if (rdy && req) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL dat_extra: got word %0h with none expected", dat);
      end else begin
        chk("dat", 32'(dat), 32'(exp_q.pop_front()));
        if (exp_q.size() == 0) exp_sd = 1'b1;
      end
    end
  end

  initial begin
    int          tries;
    logic [7:0]  t;
    int          f_trig;
    int          f_done;

    reset = 1'b1;
    start = 1'b0; adc_valid = 1'b0; adc_data = '0; thr = '0; sbf = 1'b0; req = 1'b0;
    start1 = 1'b0; adc_valid1 = 1'b0; adc_data1 = '0; thr1 = '0; sbf1 = 1'b0; req1 = 1'b0;
    #12;
    chk_reset_outputs("rst");
    chk("rst1_any", {28'd0, trd1, cd1, rdy1, sd1} | trigtm1 | 32'(dat1), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed ramp with always-ready host
    load_a();
    run_capture(8'd100, -1, -1, 0);

    // Same ramp, host accepts every other cycle
    load_a();
    run_capture(8'd100, -1, -1, 1);

    // Crossing inside FILL must not trigger; later crossing does
    for (int c = 0; c < L; c++) begin
      g_samp[c] = (c < 11) ? seq_b[c] : 8'($urandom);
      g_vld[c]  = (c < 11) ? 1'b1 : 1'($urandom);
    end
    run_capture(8'd100, -1, -1, 2);

    // Reset during POST, then a clean capture
    load_a();
    run_capture(8'd100, -1, 8, 0);
    load_a();
    run_capture(8'd100, -1, -1, 0);

    // Timestamp wrap across the trigger
    load_a();
    run_capture(8'd100, 4, -1, 2);

    // Edge mode: falling on dut1, rising on dut0, same stimulus
    for (int c = 0; c < L; c++) begin
      g_samp[c] = (c < 5) ? 8'd200 : (c == 5) ? 8'd90 : 8'd95;
      g_vld[c]  = (c < 8);
    end
    model(1, 8'd100);
    f_trig = m_trig_c;
    f_done = m_done_c;
    model(0, 8'd100);
    @(posedge clk); #1;
    start = 1'b1; start1 = 1'b1; thr = 8'd100; thr1 = 8'd100;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      start = 1'b0; start1 = 1'b0;
      adc_data = g_samp[c]; adc_valid = g_vld[c];
      adc_data1 = g_samp[c]; adc_valid1 = g_vld[c];
    end
    @(posedge clk); #1;
    adc_valid = 1'b0; adc_valid1 = 1'b0;
    chk("fall_trd",    32'(trd1), 32'(f_trig >= 0));
    chk("fall_trigtm", trigtm1,   32'(f_trig));
    chk("fall_cd",     32'(cd1),  32'(f_done >= 0));
    chk("rise_no_trd", 32'(trd),  32'(m_trig_c >= 0));
    reset = 1'b1;
    #2 reset = 1'b0;

    // Randomized episodes
    for (int e = 0; e < 8; e++) begin
      tries = 0;
      do begin
        t = 8'($urandom_range(20, 235));
        for (int c = 0; c < L; c++) begin
          g_samp[c] = 8'($urandom);
          g_vld[c]  = ($urandom_range(0, 3) != 0);
        end
        model(0, t);
        tries++;
      end while (m_done_c < 0 && tries < 50);
      run_capture(t, -1, -1, 2);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trig_surround_cache_p.md
TRIG_SURROUND_CACHE_P -- requirements
Module: trig_surround_cache_p

Interface
REQ-001 Parameter DW, 8, ADC sample width in bits.
REQ-002 Parameter PRE, 4, samples kept before the trigger sample.
REQ-003 Parameter POST, 3, samples captured after the trigger sample.
REQ-004 Parameter MODE, 0, trigger edge: 0 rising, 1 falling, 2 either.
REQ-005 Port clk  in  1  single clock; all state updates on rising edge.
REQ-006 Port reset  in  1  reset, asynchronous, active-high.
REQ-007 Port start  in  1  arm request, level sampled in IDLE.
REQ-008 Port adc_data  in  DW  ADC sample.
REQ-009 Port adc_valid  in  1  adc_data valid this cycle.
REQ-010 Port thr  in  DW  unsigned trigger threshold, sampled on start.
REQ-011 Port sbf  in  1  host request to send buffer.
REQ-012 Port req  in  1  host accepts dat this cycle.
REQ-013 Port trd  out  1  trigger detected, held until IDLE.
REQ-014 Port cd  out  1  capture done, held until SEND entered.
REQ-015 Port trigtm  out  32  timestamp of trigger sample.
REQ-016 Port rdy  out  1  dat valid.
REQ-017 Port dat  out  DW  buffered sample, oldest first.
REQ-018 Port sd  out  1  send done, one-cycle pulse.

Function
REQ-019 States IDLE, FILL, WAIT_TRIG, POST, DONE, SEND; encoding in package.
REQ-020 IDLE: start=1 -> latch thr, clear timestamp and fill count, go FILL next cycle.
REQ-021 Timestamp: 32-bit counter, +1 per cycle outside IDLE, wraps 0xFFFFFFFF -> 0.
REQ-022 Only cycles with adc_valid=1 write samples; ring buffer depth PRE+POST+1, write pointer wraps modulo depth.
REQ-023 FILL: after PRE valid samples written -> WAIT_TRIG; no trigger evaluated in FILL.
REQ-024 Trigger on valid sample s with previous valid sample p: rising p<thr and s>=thr; falling p>thr and s<=thr; MODE 2 either; unsigned compare.
REQ-025 WAIT_TRIG: samples keep overwriting oldest; on trigger, write s, latch trigtm=timestamp, set trd, go POST.
REQ-026 POST: after POST further valid samples -> DONE, cd=1; POST=0 -> DONE directly from trigger cycle.
REQ-027 DONE: sbf=1 -> SEND, cd cleared; read pointer = trigger index minus PRE modulo depth.
REQ-028 SEND: rdy=1, dat=buffer[read pointer]; word transferred when rdy and req both 1; pointer advances after transfer.
REQ-029 After transfer of word PRE+POST+1: rdy=0, sd=1 one cycle, go IDLE, trd cleared.
REQ-030 sbf outside DONE ignored; start outside IDLE ignored; adc_valid in DONE/SEND ignored (buffer frozen).
REQ-031 Trigger on the cycle FILL completes is not evaluated; earliest trigger is next valid sample.
REQ-032 Dat latency: dat valid same cycle rdy=1; next word valid cycle after transfer.

Reset
REQ-033 reset=1 asynchronously forces IDLE; trd, cd, rdy, sd=0; trigtm, dat, timestamp, pointers, counts=0.
REQ-034 Reset mid-operation abandons capture/send; buffer contents need not be cleared.

Structure
REQ-035 Package tsc_pkg holds state enum, MODE constants, TS_W=32.
REQ-036 Sub-module tsc_ring_buf: parametrised DW x depth RAM, one write, one async read port.

Verification (DW=8, PRE=4, POST=3, MODE=0, thr=100)
REQ-037 Samples 10,20,30,40,50,90,120,130,140,150 valid every cycle -> trd after 120, cd after 150, dat sequence 30,40,50,90,120,130,140,150, sd one pulse.
REQ-038 MODE=1, samples 200x5 then 90 -> trd on 90; MODE=0 same stimulus -> no trd.
REQ-039 Ramp crossing thr during FILL (sample 2=150) -> no trigger until a later crossing.
REQ-040 req toggled every other cycle in SEND -> 8 words, no duplicates or skips, sd after last.
REQ-041 reset asserted in POST -> all outputs 0 immediately; new start completes normally.
REQ-042 Timestamp preset near 0xFFFFFFFE (force) before trigger -> trigtm wraps correctly to 0x00000000 region.
